rr_select_arb4: RTL and testbench



---
 rtl/rr_select_arb4_pkg.sv | 31 +++
 rtl/rr_select_arb4.sv | 90 +++++++++
 tb/tb_rr_select_arb4.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rr_select_arb4_pkg.sv
// Shared constants and the rotating-priority pick used by the 4-source arbiter.
package rr_select_arb4_pkg;

    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 2;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // First set bit of req scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
    // The loop walks from the lowest priority slot to the highest so the
    // nearest requester after ptr overwrites any earlier candidate.
    function automatic pick_t rr_next(input logic [NUM_SRC-1:0] req,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p.found = 1'b0;
        p.idx   = ptr;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_select_arb4.sv
// Round-robin arbiter with burst locking driving the select of a registered
// 4-to-1 byte mux; q_valid lines up with the mux output register.
module rr_select_arb4
    import rr_select_arb4_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               out_ready,
    output logic [NUM_SRC-1:0] ack,
    output logic [SEL_W-1:0]   select,
    output logic               q_valid,
    output logic               busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [SEL_W-1:0] last_sel_q, last_sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             q_valid_q, q_valid_d;

    logic             lock;
    pick_t            pick;
    logic             win_vld;
    logic [SEL_W-1:0] win_idx;
    logic [CNT_W-1:0] next_cnt;

    // Winner selection: a live burst keeps its owner, otherwise rotate past ptr.
    // Grants are suppressed while reset is asserted so ack reads 0 immediately.
    always_comb begin
        lock    = busy_q & req[owner_q] & (cnt_q < MAX_CNT);
        pick    = rr_next(req, ptr_q);
        win_vld = ~rst & out_ready & (lock | pick.found);
        win_idx = lock ? owner_q : pick.idx;
        ack     = win_vld ? (NUM_SRC'(1) << win_idx) : '0;
        select  = win_vld ? win_idx : last_sel_q;
    end

    // Next-state: a transfer updates ownership and the burst count; a stall
    // (out_ready low) freezes everything so an interrupted burst resumes.
    always_comb begin
        last_sel_d = last_sel_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        q_valid_d  = 1'b0;
        next_cnt   = lock ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
        if (win_vld) begin
            last_sel_d = win_idx;
            ptr_d      = win_idx;
            owner_d    = win_idx;
            cnt_d      = next_cnt;
            busy_d     = (next_cnt < MAX_CNT);
            q_valid_d  = 1'b1;
        end else if (out_ready && (req == '0)) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end
    end

    // State registers; ptr resets to 3 so source 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sel_q <= '0;
            ptr_q      <= SEL_W'(NUM_SRC - 1);
            owner_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            q_valid_q  <= 1'b0;
        end else begin
            last_sel_q <= last_sel_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            q_valid_q  <= q_valid_d;
        end
    end

    assign q_valid = q_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rr_select_arb4.sv
// Bench for rr_select_arb4: two instances (MAX_BURST=1 and 4) each feeding a
// bench-side registered mux; expected bytes are queued at grant time and
// popped when q_valid is expected.
module tb_rr_select_arb4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req1, req4;
    logic       rdy1, rdy4;
    logic [3:0] ack1, ack4;
    logic [1:0] sel1, sel4;
    logic       qv1, qv4, busy1, busy4;
    logic [7:0] q1, q4;
    logic [7:0] data [0:3] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    logic [7:0] sb [$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    rr_select_arb4 #(.MAX_BURST(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .req(req1), .out_ready(rdy1),
        .ack(ack1), .select(sel1), .q_valid(qv1), .busy(busy1));

    rr_select_arb4 #(.MAX_BURST(4), .CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .req(req4), .out_ready(rdy4),
        .ack(ack4), .select(sel4), .q_valid(qv4), .busy(busy4));

    // Downstream registered mux model
    always @(posedge clk) begin
        q1 <= data[sel1];
        q4 <= data[sel4];
    end

    task automatic do_reset();
        rst = 1'b1; req1 = '0; req4 = '0; rdy1 = 1'b1; rdy4 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        req4 = 4'b1110; req1 = 4'b1111;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (ack4 !== 4'b0000) begin failures++; $display("FAIL rst_ack got=%b exp=0000", ack4); end
        checks++; if (sel4 !== 2'd0) begin failures++; $display("FAIL rst_sel got=%0d exp=0", sel4); end
        checks++; if (qv4 !== 1'b0) begin failures++; $display("FAIL rst_qvalid got=%b exp=0", qv4); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy4); end
        checks++; if (ack1 !== 4'b0000) begin failures++; $display("FAIL rst_ack1 got=%b exp=0000", ack1); end
        @(posedge clk);
        #1 rst = 1'b0; req4 = 4'b1111;
        #1;
        checks++; if (ack4 !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b exp=0001", ack4); end
        req4 = '0; req1 = '0;
        sb.delete();
    endtask

    task automatic test_rr_pure();
        logic [3:0] rq [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] ea [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
        logic [7:0] eb;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req1 = rq[i]; rdy1 = 1'b1;
            #1;
            checks++; if (ack1 !== ea[i]) begin failures++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", i, ack1, ea[i]); end
            for (int b = 0; b < 4; b++) if (ea[i][b]) sb.push_back(data[b]);
            @(posedge clk); #1;
            checks++; if (qv1 !== (sb.size() != 0)) begin failures++; $display("FAIL rr_qvalid cyc=%0d got=%b exp=%b", i, qv1, sb.size() != 0); end
            if (sb.size() != 0) begin
                eb = sb.pop_front();
                checks++; if (q1 !== eb) begin failures++; $display("FAIL rr_q cyc=%0d got=%h exp=%h", i, q1, eb); end
            end
        end
    endtask

    task automatic test_burst();
        logic [3:0] rq [10] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                                4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
        logic [3:0] ea [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100,
                                4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000};
        logic       eby [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] eb;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req4 = rq[i]; rdy4 = 1'b1;
            #1;
            checks++; if (ack4 !== ea[i]) begin failures++; $display("FAIL burst_ack cyc=%0d got=%b exp=%b", i, ack4, ea[i]); end
            for (int b = 0; b < 4; b++) if (ea[i][b]) sb.push_back(data[b]);
            @(posedge clk); #1;
            checks++; if (busy4 !== eby[i]) begin failures++; $display("FAIL burst_busy cyc=%0d got=%b exp=%b", i, busy4, eby[i]); end
            checks++; if (qv4 !== (sb.size() != 0)) begin failures++; $display("FAIL burst_qvalid cyc=%0d got=%b exp=%b", i, qv4, sb.size() != 0); end
            if (sb.size() != 0) begin
                eb = sb.pop_front();
                checks++; if (q4 !== eb) begin failures++; $display("FAIL burst_q cyc=%0d got=%h exp=%h", i, q4, eb); end
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] rq [9] = '{4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0011,
                               4'b0011, 4'b0011, 4'b0011, 4'b0000};
        logic       rd [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] ea [9] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                               4'b0010, 4'b0010, 4'b0001, 4'b0000};
        logic [1:0] es [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        logic       eby [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] eb;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req4 = rq[i]; rdy4 = rd[i];
            #1;
            checks++; if (ack4 !== ea[i]) begin failures++; $display("FAIL stall_ack cyc=%0d got=%b exp=%b", i, ack4, ea[i]); end
            checks++; if (sel4 !== es[i]) begin failures++; $display("FAIL stall_sel cyc=%0d got=%0d exp=%0d", i, sel4, es[i]); end
            for (int b = 0; b < 4; b++) if (ea[i][b]) sb.push_back(data[b]);
            @(posedge clk); #1;
            checks++; if (busy4 !== eby[i]) begin failures++; $display("FAIL stall_busy cyc=%0d got=%b exp=%b", i, busy4, eby[i]); end
            checks++; if (qv4 !== (sb.size() != 0)) begin failures++; $display("FAIL stall_qvalid cyc=%0d got=%b exp=%b", i, qv4, sb.size() != 0); end
            if (sb.size() != 0) begin
                eb = sb.pop_front();
                checks++; if (q4 !== eb) begin failures++; $display("FAIL stall_q cyc=%0d got=%h exp=%h", i, q4, eb); end
            end
        end
        rdy4 = 1'b1;
    endtask

    task automatic test_owner_drop();
        logic [3:0] rq [4] = '{4'b1000, 4'b0001, 4'b0001, 4'b0000};
        logic [3:0] ea [4] = '{4'b1000, 4'b0001, 4'b0001, 4'b0000};
        logic       eby [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] eb;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req4 = rq[i]; rdy4 = 1'b1;
            #1;
            checks++; if (ack4 !== ea[i]) begin failures++; $display("FAIL drop_ack cyc=%0d got=%b exp=%b", i, ack4, ea[i]); end
            for (int b = 0; b < 4; b++) if (ea[i][b]) sb.push_back(data[b]);
            @(posedge clk); #1;
            checks++; if (busy4 !== eby[i]) begin failures++; $display("FAIL drop_busy cyc=%0d got=%b exp=%b", i, busy4, eby[i]); end
            checks++; if (qv4 !== (sb.size() != 0)) begin failures++; $display("FAIL drop_qvalid cyc=%0d got=%b exp=%b", i, qv4, sb.size() != 0); end
            if (sb.size() != 0) begin
                eb = sb.pop_front();
                checks++; if (q4 !== eb) begin failures++; $display("FAIL drop_q cyc=%0d got=%h exp=%h", i, q4, eb); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rq [3] = '{4'b0100, 4'b0001, 4'b0000};
        logic [3:0] ea [3] = '{4'b0100, 4'b0001, 4'b0000};
        logic [7:0] eq [2] = '{8'h3C, 8'hA5};
        logic [7:0] eb;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req4 = rq[i]; rdy4 = 1'b1;
            #1;
            checks++; if (ack4 !== ea[i]) begin failures++; $display("FAIL b2b_ack cyc=%0d got=%b exp=%b", i, ack4, ea[i]); end
            if (i < 2) sb.push_back(eq[i]);
            @(posedge clk); #1;
            checks++; if (qv4 !== (sb.size() != 0)) begin failures++; $display("FAIL b2b_qvalid cyc=%0d got=%b exp=%b", i, qv4, sb.size() != 0); end
            if (sb.size() != 0) begin
                eb = sb.pop_front();
                checks++; if (q4 !== eb) begin failures++; $display("FAIL b2b_q cyc=%0d got=%h exp=%h", i, q4, eb); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req1 = '0; req4 = '0; rdy1 = 1'b1; rdy4 = 1'b1;
        test_reset();
        test_rr_pure();
        test_burst();
        test_stall();
        test_owner_drop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
